// File: rtl/shim_rd_arbiter_pkg.sv
// Shared types for the two-port read arbiter in front of the AXI shim.
// Field widths that do not depend on module parameters live here.
package shim_rd_arbiter_pkg;

    typedef logic [7:0] blen_t;
    typedef logic [1:0] size_t;
    typedef logic [1:0] port_vec_t;

    typedef enum logic {
        IDLE,
        HOLD
    } state_e;

endpackage

// File: rtl/shim_rd_arbiter_if.sv
// Shim-side read channel: one request handshake plus the response beat stream.
// The arbiter drives the request half through the master modport.
interface shim_rd_arbiter_if
    import shim_rd_arbiter_pkg::*;
#(
    parameter int AddrWidth = 64,
    parameter int DataWidth = 64,
    parameter int IdWidth   = 4
);

    logic                 rd_req;
    logic                 rd_gnt;
    logic [AddrWidth-1:0] rd_addr;
    blen_t                rd_blen;
    size_t                rd_size;
    logic                 rd_lock;
    logic [IdWidth-1:0]   rd_id;

    logic                 rd_valid;
    logic                 rd_rdy;
    logic                 rd_last;
    logic [DataWidth-1:0] rd_data;
    logic                 rd_exokay;
    logic [IdWidth-1:0]   rd_rsp_id;

    modport master (
        output rd_req, rd_addr, rd_blen, rd_size, rd_lock, rd_id, rd_rdy,
        input  rd_gnt, rd_valid, rd_last, rd_data, rd_exokay, rd_rsp_id
    );

    modport slave (
        input  rd_req, rd_addr, rd_blen, rd_size, rd_lock, rd_id, rd_rdy,
        output rd_gnt, rd_valid, rd_last, rd_data, rd_exokay, rd_rsp_id
    );

endinterface

// File: rtl/shim_rd_arbiter_rr_arb2.sv
// Two-way round-robin picker: on a tie the port that did not win last time wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            gnt = last_gnt ? 2'b01 : 2'b10;
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/shim_rd_arbiter.sv
// Arbitrates two read requesters onto one shim read port, tags the shim ID with
// the port number, routes responses back by that tag and tracks bursts in flight.
module shim_rd_arbiter
    import shim_rd_arbiter_pkg::*;
#(
    parameter int AxiAddrWidth   = 64,
    parameter int AxiDataWidth   = 64,
    parameter int AxiIdWidth     = 4,
    parameter int MaxOutstanding = 4
) (
    input  logic                                clk_i,
    input  logic                                rst_i,

    input  logic [1:0]                          req_i,
    output logic [1:0]                          gnt_o,
    input  logic [1:0][AxiAddrWidth-1:0]        addr_i,
    input  logic [1:0][7:0]                     blen_i,
    input  logic [1:0][1:0]                     size_i,
    input  logic [1:0][AxiIdWidth-2:0]          id_i,
    input  logic [1:0]                          lock_i,

    output logic [1:0]                          valid_o,
    input  logic [1:0]                          rdy_i,
    output logic [1:0]                          last_o,
    output logic [1:0][AxiDataWidth-1:0]        data_o,
    output logic [1:0][AxiIdWidth-2:0]          id_o,
    output logic [1:0]                          exokay_o,

    shim_rd_arbiter_if.master                   shim,

    output logic                                unexpected_rsp_o
);

    localparam int CntWidth = $clog2(MaxOutstanding + 1);
    localparam logic [CntWidth-1:0] MaxCount = CntWidth'(MaxOutstanding);

    state_e                     state;
    state_e                     next_state;
    logic                       sel;
    logic                       last_gnt;
    logic                       granted;
    port_vec_t                  eligible;
    port_vec_t                  pick;
    port_vec_t                  rsp_done;
    logic                       rsp_port;
    logic [1:0][CntWidth-1:0]   count;

    logic [AxiAddrWidth-1:0]    addr_q;
    blen_t                      blen_q;
    size_t                      size_q;
    logic                       lock_q;
    logic [AxiIdWidth-2:0]      id_q;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            eligible[p] = req_i[p] && (count[p] < MaxCount);
        end
    end

    rr_arb2 u_rr_arb2 (
        .req      (eligible),
        .last_gnt (last_gnt),
        .gnt      (pick)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        gnt_o      = 2'b00;
        granted    = 1'b0;
        case (state)
            IDLE: begin
                if (|eligible) begin
                    next_state = HOLD;
                end
            end
            HOLD: begin
                if (shim.rd_gnt) begin
                    granted    = 1'b1;
                    gnt_o[sel] = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // The request is captured on entry to HOLD so the requester may drop req_i
    // without disturbing what the shim sees.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sel    <= 1'b0;
            addr_q <= '0;
            blen_q <= '0;
            size_q <= '0;
            lock_q <= 1'b0;
            id_q   <= '0;
        end else if (state == IDLE && (|eligible)) begin
            sel    <= pick[1];
            addr_q <= addr_i[pick[1]];
            blen_q <= blen_i[pick[1]];
            size_q <= size_i[pick[1]];
            lock_q <= lock_i[pick[1]];
            id_q   <= id_i[pick[1]];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_gnt <= 1'b1;
        end else if (granted) begin
            last_gnt <= sel;
        end
    end

    assign shim.rd_req  = (state == HOLD);
    assign shim.rd_addr = addr_q;
    assign shim.rd_blen = blen_q;
    assign shim.rd_size = size_q;
    assign shim.rd_lock = lock_q;
    assign shim.rd_id   = {sel, id_q};

    assign rsp_port    = shim.rd_rsp_id[AxiIdWidth-1];
    assign valid_o     = {shim.rd_valid & rsp_port, shim.rd_valid & ~rsp_port};
    assign shim.rd_rdy = rdy_i[rsp_port];
    assign last_o      = {2{shim.rd_last}};
    assign exokay_o    = {2{shim.rd_exokay}};
    assign data_o      = {shim.rd_data, shim.rd_data};
    assign id_o        = {shim.rd_rsp_id[AxiIdWidth-2:0], shim.rd_rsp_id[AxiIdWidth-2:0]};

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rsp_done[p] = shim.rd_valid && shim.rd_rdy && shim.rd_last && (rsp_port == p[0]);
        end
    end

    // A last beat for a port with nothing in flight is flagged rather than counted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (granted && (sel == p[0]) && !rsp_done[p]) begin
                    count[p] <= count[p] + 1'b1;
                end else if (rsp_done[p] && !(granted && (sel == p[0])) && (count[p] != '0)) begin
                    count[p] <= count[p] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            unexpected_rsp_o <= 1'b0;
        end else if ((rsp_done[0] && count[0] == '0) || (rsp_done[1] && count[1] == '0)) begin
            unexpected_rsp_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_shim_rd_arbiter.sv
// Directed bench for shim_rd_arbiter: arbitration order, field capture,
// response routing, outstanding limits, unexpected-response flag and reset.
module tb_shim_rd_arbiter;

    localparam int AddrW = 64;
    localparam int DataW = 64;
    localparam int IdW   = 4;

    logic                        clk;
    logic                        rst;
    logic [1:0]                  req_i;
    logic [1:0]                  gnt_o;
    logic [1:0][AddrW-1:0]       addr_i;
    logic [1:0][7:0]             blen_i;
    logic [1:0][1:0]             size_i;
    logic [1:0][IdW-2:0]         id_i;
    logic [1:0]                  lock_i;
    logic [1:0]                  valid_o;
    logic [1:0]                  rdy_i;
    logic [1:0]                  last_o;
    logic [1:0][DataW-1:0]       data_o;
    logic [1:0][IdW-2:0]         id_o;
    logic [1:0]                  exokay_o;
    logic                        unexpected_rsp_o;

    int checks;
    int errors;

    shim_rd_arbiter_if #(.AddrWidth(AddrW), .DataWidth(DataW), .IdWidth(IdW)) shim_bus ();

    shim_rd_arbiter #(
        .AxiAddrWidth   (AddrW),
        .AxiDataWidth   (DataW),
        .AxiIdWidth     (IdW),
        .MaxOutstanding (4)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .req_i            (req_i),
        .gnt_o            (gnt_o),
        .addr_i           (addr_i),
        .blen_i           (blen_i),
        .size_i           (size_i),
        .id_i             (id_i),
        .lock_i           (lock_i),
        .valid_o          (valid_o),
        .rdy_i            (rdy_i),
        .last_o           (last_o),
        .data_o           (data_o),
        .id_o             (id_o),
        .exokay_o         (exokay_o),
        .shim             (shim_bus.master),
        .unexpected_rsp_o (unexpected_rsp_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int port, input logic [AddrW-1:0] addr, input logic [7:0] blen,
                                 input logic [1:0] size, input logic [IdW-2:0] id);
        addr_i[port] = addr;
        blen_i[port] = blen;
        size_i[port] = size;
        id_i[port]   = id;
        lock_i[port] = 1'b0;
    endtask

    task automatic driveBeat(input logic valid, input logic last, input logic [IdW-1:0] id, input logic [1:0] rdy);
        shim_bus.rd_valid  = valid;
        shim_bus.rd_last   = last;
        shim_bus.rd_rsp_id = id;
        rdy_i              = rdy;
    endtask

    logic [1:0] alt_pattern [6];

    initial begin
        checks = 0;
        errors = 0;
        alt_pattern = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
        rst    = 1'b1;
        req_i  = 2'b00;
        addr_i = '0;
        blen_i = '0;
        size_i = '0;
        id_i   = '0;
        lock_i = 2'b00;
        rdy_i  = 2'b00;
        shim_bus.rd_gnt    = 1'b0;
        shim_bus.rd_valid  = 1'b0;
        shim_bus.rd_last   = 1'b0;
        shim_bus.rd_data   = '0;
        shim_bus.rd_exokay = 1'b0;
        shim_bus.rd_rsp_id = '0;

        @(negedge clk);
        @(negedge clk);
        checkOutput("reset rd_req", 64'(shim_bus.rd_req), 64'd0);
        checkOutput("reset gnt", 64'(gnt_o), 64'd0);
        checkOutput("reset unexpected", 64'(unexpected_rsp_o), 64'd0);
        checkOutput("reset rd_addr", 64'(shim_bus.rd_addr), 64'd0);
        rst = 1'b0;

        // Single request on port 0, granted after two HOLD cycles
        applyStimulus(0, 64'h1000, 8'd3, 2'd3, 3'b101);
        req_i = 2'b01;
        @(negedge clk);
        checkOutput("hold rd_req", 64'(shim_bus.rd_req), 64'd1);
        checkOutput("hold rd_addr", 64'(shim_bus.rd_addr), 64'h1000);
        checkOutput("hold rd_blen", 64'(shim_bus.rd_blen), 64'd3);
        checkOutput("hold rd_size", 64'(shim_bus.rd_size), 64'd3);
        checkOutput("hold rd_id", 64'(shim_bus.rd_id), 64'b0101);
        checkOutput("hold no gnt", 64'(gnt_o), 64'd0);
        @(negedge clk);
        checkOutput("hold still rd_req", 64'(shim_bus.rd_req), 64'd1);
        shim_bus.rd_gnt = 1'b1;
        #1;
        checkOutput("gnt pulse port0", 64'(gnt_o), 64'b01);
        @(negedge clk);
        shim_bus.rd_gnt = 1'b0;
        req_i = 2'b00;
        checkOutput("gnt one cycle", 64'(gnt_o), 64'b00);
        checkOutput("idle rd_req", 64'(shim_bus.rd_req), 64'd0);
        checkOutput("count0 after gnt", 64'(dut.count[0]), 64'd1);

        // Drain port 0 with one last beat
        driveBeat(1'b1, 1'b1, 4'b0000, 2'b01);
        @(negedge clk);
        driveBeat(1'b0, 1'b0, 4'b0000, 2'b00);
        checkOutput("count0 drained", 64'(dut.count[0]), 64'd0);
        checkOutput("no unexpected", 64'(unexpected_rsp_o), 64'd0);

        // Combinational response routing to port 1
        shim_bus.rd_data   = 64'hDEAD_BEEF;
        shim_bus.rd_exokay = 1'b1;
        driveBeat(1'b1, 1'b0, 4'b1010, 2'b10);
        #1;
        checkOutput("route valid", 64'(valid_o), 64'b10);
        checkOutput("route id_o", 64'(id_o[1]), 64'b010);
        checkOutput("route rdy", 64'(shim_bus.rd_rdy), 64'd1);
        checkOutput("bcast data0", 64'(data_o[0]), 64'hDEAD_BEEF);
        checkOutput("bcast exokay", 64'(exokay_o), 64'b11);
        rdy_i = 2'b01;
        #1;
        checkOutput("route rdy other", 64'(shim_bus.rd_rdy), 64'd0);
        driveBeat(1'b1, 1'b0, 4'b0001, 2'b01);
        #1;
        checkOutput("route valid p0", 64'(valid_o), 64'b01);
        @(negedge clk);
        driveBeat(1'b0, 1'b0, 4'b0000, 2'b00);
        shim_bus.rd_exokay = 1'b0;

        // Both ports requesting, shim always granting: port 1 first since port 0 won last
        applyStimulus(1, 64'h2000, 8'd1, 2'd2, 3'b011);
        req_i = 2'b11;
        shim_bus.rd_gnt = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput($sformatf("alternate %0d", i), 64'(gnt_o), 64'(alt_pattern[i]));
        end
        req_i = 2'b00;
        checkOutput("alt count0", 64'(dut.count[0]), 64'd1);
        checkOutput("alt count1", 64'(dut.count[1]), 64'd2);

        // Fill port 1 to the limit, then it must be skipped
        req_i = 2'b10;
        repeat (4) @(negedge clk);
        checkOutput("count1 full", 64'(dut.count[1]), 64'd4);
        @(negedge clk);
        checkOutput("full no rd_req", 64'(shim_bus.rd_req), 64'd0);
        checkOutput("full no gnt", 64'(gnt_o), 64'd0);
        req_i = 2'b11;
        @(negedge clk);
        checkOutput("port0 while p1 full", 64'(gnt_o), 64'b01);
        @(negedge clk);
        checkOutput("count0 two", 64'(dut.count[0]), 64'd2);
        req_i = 2'b10;
        driveBeat(1'b1, 1'b1, 4'b1110, 2'b10);
        @(negedge clk);
        driveBeat(1'b0, 1'b0, 4'b0000, 2'b00);
        checkOutput("count1 freed", 64'(dut.count[1]), 64'd3);
        checkOutput("freed idle", 64'(gnt_o), 64'b00);
        @(negedge clk);
        checkOutput("port1 eligible again", 64'(gnt_o), 64'b10);
        @(negedge clk);
        checkOutput("count1 refilled", 64'(dut.count[1]), 64'd4);
        req_i = 2'b00;
        shim_bus.rd_gnt = 1'b0;

        // Reset while HOLD is waiting for the shim
        req_i = 2'b01;
        @(negedge clk);
        checkOutput("pre-reset hold", 64'(shim_bus.rd_req), 64'd1);
        rst = 1'b1;
        shim_bus.rd_gnt = 1'b1;
        #1;
        checkOutput("async drop rd_req", 64'(shim_bus.rd_req), 64'd0);
        checkOutput("reset no gnt", 64'(gnt_o), 64'b00);
        checkOutput("reset count0", 64'(dut.count[0]), 64'd0);
        checkOutput("reset count1", 64'(dut.count[1]), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        shim_bus.rd_gnt = 1'b0;
        req_i = 2'b00;

        // Last beat with nothing outstanding sets the sticky flag
        driveBeat(1'b1, 1'b1, 4'b0011, 2'b01);
        @(negedge clk);
        driveBeat(1'b0, 1'b0, 4'b0000, 2'b00);
        checkOutput("unexpected set", 64'(unexpected_rsp_o), 64'd1);
        checkOutput("no underflow", 64'(dut.count[0]), 64'd0);
        repeat (3) @(negedge clk);
        checkOutput("unexpected sticky", 64'(unexpected_rsp_o), 64'd1);

        // Pointer favours port 0 again after reset
        req_i = 2'b11;
        shim_bus.rd_gnt = 1'b1;
        @(negedge clk);
        checkOutput("post-reset port0 wins", 64'(gnt_o), 64'b01);
        req_i = 2'b00;
        shim_bus.rd_gnt = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shim_rd_arbiter.md
SHIM_RD_ARBITER -- requirements
Module: shim_rd_arbiter

Interface
REQ-001 SHALL have parameter AxiAddrWidth, default 64, request address width.
REQ-002 SHALL have parameter AxiDataWidth, default 64, response data width.
REQ-003 SHALL have parameter AxiIdWidth, default 4, shim-side ID width; requester IDs use AxiIdWidth-1 bits.
REQ-004 SHALL have parameter MaxOutstanding, default 4, per-port in-flight read-burst limit.
REQ-005 SHALL have one clock and an asynchronous, active-high reset: clk_i, in, 1, rising-edge clock; rst_i, in, 1, asynchronous active-high reset.
REQ-006 Requester side, [1:0] per port: req_i in 1; gnt_o out 1; addr_i in AxiAddrWidth; blen_i in 8; size_i in 2; id_i in AxiIdWidth-1; lock_i in 1.
REQ-007 Requester response, [1:0] per port: valid_o out 1; rdy_i in 1; last_o out 1; data_o out AxiDataWidth; id_o out AxiIdWidth-1; exokay_o out 1.
REQ-008 Shim request: rd_req_o out 1; rd_gnt_i in 1; rd_addr_o, rd_blen_o, rd_size_o, rd_lock_o out; rd_id_o out AxiIdWidth = {port, id}.
REQ-009 Shim response: rd_valid_i in 1; rd_rdy_o out 1; rd_last_i, rd_data_i, rd_exokay_i in; rd_id_i in AxiIdWidth.
REQ-010 SHALL have unexpected_rsp_o out 1, sticky error flag.

Function
REQ-011 SHALL implement FSM IDLE/HOLD; IDLE -> HOLD when an eligible port requests, latching sel.
REQ-012 Eligible port: req_i high and outstanding count < MaxOutstanding.
REQ-013 Both eligible in IDLE: SHALL pick the port not granted last (round-robin); after reset port 0 wins.
REQ-014 In HOLD, rd_req_o SHALL be 1 and all rd_* request fields SHALL be registered copies of sel's inputs, stable until rd_gnt_i.
REQ-015 HOLD with rd_gnt_i=1: gnt_o[sel] SHALL be 1 that cycle only, rr pointer updates, FSM -> IDLE; re-arbitration next cycle (max one grant per 2 cycles).
REQ-016 gnt_o[p] SHALL never be 1 except in HOLD with rd_gnt_i=1 and p==sel.
REQ-017 Requester SHALL hold req_i and fields until gnt_o; dropping req_i in HOLD does not withdraw the latched request.
REQ-018 Response routing SHALL be combinational: port p = rd_id_i[AxiIdWidth-1]; valid_o[p] = rd_valid_i; valid_o[other] = 0; rd_rdy_o = rdy_i[p].
REQ-019 data_o/last_o/exokay_o SHALL be broadcast to both ports; id_o = rd_id_i[AxiIdWidth-2:0].
REQ-020 Per-port counter (width clog2(MaxOutstanding+1)) SHALL +1 on grant, -1 on rd_valid_i & rd_rdy_o & rd_last_i for that port; both same cycle -> unchanged.
REQ-021 Last beat for a port with count 0 SHALL set unexpected_rsp_o (sticky until reset); counter SHALL not underflow.
REQ-022 Port at MaxOutstanding SHALL not be selected; counter SHALL never exceed MaxOutstanding.

Reset
REQ-023 During rst_i, FSM=IDLE, rr pointer favours port 0, counters=0, unexpected_rsp_o=0, rd_req_o=0, gnt_o=0, registered fields=0.
REQ-024 Reset asserted in HOLD SHALL drop rd_req_o immediately (asynchronous); pending request lost, no gnt_o issued.

Structure
REQ-025 Request/response field widths and FSM state enum SHALL live in the shared shim package as typedefs.
REQ-026 Round-robin selection SHALL be one sub-module rr_arb2 (2 requests, last-grant input, one-hot output).

Verification
REQ-027 Single req port 0 addr 0x1000 blen 3, rd_gnt_i after 2 cycles -> rd_id_o={0,id}, gnt_o[0] pulse 1 cycle, count0=1.
REQ-028 Both ports request continuously, rd_gnt_i=1 always -> grants alternate 0,1,0,1 every 2 cycles.
REQ-029 Port 1 issues 4 grants with MaxOutstanding=4, no responses -> port 1 ineligible, port 0 still granted; one last beat id={1,x} -> port 1 eligible next cycle.
REQ-030 Response rd_id_i=4'b1010, rdy_i=2'b10 -> valid_o=2'b10, id_o=3'b010, rd_rdy_o=1; rdy_i=2'b01 -> rd_rdy_o=0.
REQ-031 Last beat id={0,x} with count0=0 -> unexpected_rsp_o=1 and stays 1; count0 stays 0.
REQ-032 rst_i in HOLD before rd_gnt_i -> rd_req_o=0 same cycle, counters 0, no gnt_o pulse.
